// File: rtl/ctrl_msg_rx.sv
// ctrl_msg_rx: parses a tready-less AXIS control stream. Frames that carry the
// slot-start ethertype in beat 1 commit a slot ID and destination MAC. Prefixed
// messages (timestamp / standard time / return timestamp) capture the next
// beat into a held 64-bit output. Bad or oversized frames bump a saturating
// error counter.
module ctrl_msg_rx #(
    parameter logic [15:0] P_SLOT_ID_TYPE = 16'hff03,
    parameter int          P_SLOT_ID_W    = 4,
    parameter logic [7:0]  P_TS_PRE       = 8'h66,
    parameter logic [7:0]  P_STD_PRE      = 8'h88,
    parameter logic [7:0]  P_RET_PRE      = 8'h55,
    parameter int          P_MAX_BEATS    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   s_ctrl_rx_axis_tvalid,
    input  logic [63:0]            s_ctrl_rx_axis_tdata,
    input  logic                   s_ctrl_rx_axis_tlast,
    input  logic [7:0]             s_ctrl_rx_axis_tkeep,
    input  logic                   s_ctrl_rx_axis_tuser,
    output logic [63:0]            o_recv_time_stamp,
    output logic [63:0]            o_recv_std_time,
    output logic [63:0]            o_recv_return_ts,
    output logic                   o_recv_ts_valid,
    output logic                   o_recv_std_valid,
    output logic                   o_recv_return_valid,
    output logic [P_SLOT_ID_W-1:0] o_cur_slot_id,
    output logic [47:0]            o_dest_tor_mac,
    output logic                   o_syn_start,
    output logic [15:0]            o_err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DROP} state_t;
    typedef enum logic [1:0] {ARM_NONE, ARM_TS, ARM_STD, ARM_RET} arm_t;

    localparam logic [16:0] MAX_BEATS_C = 17'(P_MAX_BEATS);

    state_t                 state_q, state_d;
    arm_t                   arm_q, arm_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            hdr_q, hdr_d;
    logic                   bad_q, bad_d;
    logic                   pend_q, pend_d;
    logic [47:0]            pend_mac_q, pend_mac_d;
    logic [P_SLOT_ID_W-1:0] pend_id_q, pend_id_d;
    logic [63:0]            ts_q, ts_d, std_q, std_d, ret_q, ret_d;
    logic                   ts_v_q, ts_v_d, std_v_q, std_v_d, ret_v_q, ret_v_d;
    logic [P_SLOT_ID_W-1:0] slot_q, slot_d;
    logic [47:0]            mac_q, mac_d;
    logic                   syn_q, syn_d;
    logic [15:0]            err_q, err_d;

    logic [16:0]            cnt_inc;
    logic                   hit_max;
    logic                   unused_tkeep;

    // Byte enables carry no meaning for this control stream.
    assign unused_tkeep = ^s_ctrl_rx_axis_tkeep;

    // A beat that would make the frame reach the length limit without ending it.
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
    assign hit_max = s_ctrl_rx_axis_tvalid && !s_ctrl_rx_axis_tlast
                     && (state_q != S_DROP) && (cnt_inc >= MAX_BEATS_C);

    // Next-state and next-output logic for the whole parser, evaluated per beat.
    always_comb begin
        // NOTE: every _d takes its hold value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        arm_d      = arm_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        bad_d      = bad_q;
        pend_d     = pend_q;
        pend_mac_d = pend_mac_q;
        pend_id_d  = pend_id_q;
        ts_d       = ts_q;
        std_d      = std_q;
        ret_d      = ret_q;
        slot_d     = slot_q;
        mac_d      = mac_q;
        err_d      = err_q;
        ts_v_d     = 1'b0;
        std_v_d    = 1'b0;
        ret_v_d    = 1'b0;
        syn_d      = 1'b0;

        if (s_ctrl_rx_axis_tvalid) begin
            cnt_d = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
            if (s_ctrl_rx_axis_tuser) begin
                bad_d = 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    hdr_d   = s_ctrl_rx_axis_tdata[15:0];
                    state_d = S_HDR;
                end
                S_HDR: begin
                    if (s_ctrl_rx_axis_tdata[31:16] == P_SLOT_ID_TYPE) begin
                        pend_d     = 1'b1;
                        pend_mac_d = {hdr_q, s_ctrl_rx_axis_tdata[63:32]};
                        pend_id_d  = s_ctrl_rx_axis_tdata[P_SLOT_ID_W-1:0];
                    end
                    state_d = S_BODY;
                end
                S_BODY: state_d = S_BODY;
                S_DROP: state_d = S_DROP;
                default: state_d = S_IDLE;
            endcase

            if (hit_max) begin
                state_d = S_DROP;
            end

            // An armed capture lasts exactly one beat: take it if clean, else discard.
            if (arm_q != ARM_NONE) begin
                arm_d = ARM_NONE;
                if (!s_ctrl_rx_axis_tuser && !hit_max) begin
                    unique case (arm_q)
                        ARM_TS:  begin ts_d  = s_ctrl_rx_axis_tdata; ts_v_d  = 1'b1; end
                        ARM_STD: begin std_d = s_ctrl_rx_axis_tdata; std_v_d = 1'b1; end
                        ARM_RET: begin ret_d = s_ctrl_rx_axis_tdata; ret_v_d = 1'b1; end
                        default: ;
                    endcase
                end
            end else if ((state_q == S_HDR || state_q == S_BODY) && !s_ctrl_rx_axis_tuser
                         && !s_ctrl_rx_axis_tlast && !hit_max) begin
                if (s_ctrl_rx_axis_tdata == {56'h0, P_TS_PRE}) begin
                    arm_d = ARM_TS;
                end else if (s_ctrl_rx_axis_tdata == {56'h0, P_STD_PRE}) begin
                    arm_d = ARM_STD;
                end else if (s_ctrl_rx_axis_tdata == {56'h0, P_RET_PRE}) begin
                    arm_d = ARM_RET;
                end
            end

            // End of frame: either count it as bad or commit a pending slot start.
            if (s_ctrl_rx_axis_tlast) begin
                if (bad_q || s_ctrl_rx_axis_tuser || state_q == S_DROP) begin
                    err_d = (err_q == 16'hffff) ? err_q : err_q + 16'd1;
                end else if (pend_d) begin
                    mac_d  = pend_mac_d;
                    slot_d = pend_id_d;
                    syn_d  = 1'b1;
                end
                state_d = S_IDLE;
                arm_d   = ARM_NONE;
                cnt_d   = 16'd0;
                bad_d   = 1'b0;
                pend_d  = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= S_IDLE;
            arm_q      <= ARM_NONE;
            cnt_q      <= '0;
            hdr_q      <= '0;
            bad_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_mac_q <= '0;
            pend_id_q  <= '0;
            ts_q       <= '0;
            std_q      <= '0;
            ret_q      <= '0;
            ts_v_q     <= 1'b0;
            std_v_q    <= 1'b0;
            ret_v_q    <= 1'b0;
            slot_q     <= '0;
            mac_q      <= '0;
            syn_q      <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            bad_q      <= bad_d;
            pend_q     <= pend_d;
            pend_mac_q <= pend_mac_d;
            pend_id_q  <= pend_id_d;
            ts_q       <= ts_d;
            std_q      <= std_d;
            ret_q      <= ret_d;
            ts_v_q     <= ts_v_d;
            std_v_q    <= std_v_d;
            ret_v_q    <= ret_v_d;
            slot_q     <= slot_d;
            mac_q      <= mac_d;
            syn_q      <= syn_d;
            err_q      <= err_d;
        end
    end

    assign o_recv_time_stamp   = ts_q;
    assign o_recv_std_time     = std_q;
    assign o_recv_return_ts    = ret_q;
    assign o_recv_ts_valid     = ts_v_q;
    assign o_recv_std_valid    = std_v_q;
    assign o_recv_return_valid = ret_v_q;
    assign o_cur_slot_id       = slot_q;
    assign o_dest_tor_mac      = mac_q;
    assign o_syn_start         = syn_q;
    assign o_err_cnt           = err_q;

endmodule

// File: tb/tb_ctrl_msg_rx.sv
// tb_ctrl_msg_rx: directed and randomized stimulus for ctrl_msg_rx, checked
// every cycle against a frame-index based reference model, plus literal
// expectations for the headline scenarios.
module tb_ctrl_msg_rx;

    localparam int MAXB = 16;

    localparam int SEL_TS   = 0;
    localparam int SEL_STD  = 1;
    localparam int SEL_RET  = 2;
    localparam int SEL_TSV  = 3;
    localparam int SEL_STDV = 4;
    localparam int SEL_RETV = 5;
    localparam int SEL_SLOT = 6;
    localparam int SEL_MAC  = 7;
    localparam int SEL_SYN  = 8;
    localparam int SEL_ERR  = 9;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        tvalid = 1'b0;
    logic [63:0] tdata = '0;
    logic        tlast = 1'b0;
    logic [7:0]  tkeep = 8'hff;
    logic        tuser = 1'b0;

    logic [63:0] o_ts, o_std, o_ret;
    logic        o_tsv, o_stdv, o_retv;
    logic [3:0]  o_slot;
    logic [47:0] o_mac;
    logic        o_syn;
    logic [15:0] o_err;

    ctrl_msg_rx #(.P_MAX_BEATS(MAXB)) dut (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .s_ctrl_rx_axis_tvalid (tvalid),
        .s_ctrl_rx_axis_tdata  (tdata),
        .s_ctrl_rx_axis_tlast  (tlast),
        .s_ctrl_rx_axis_tkeep  (tkeep),
        .s_ctrl_rx_axis_tuser  (tuser),
        .o_recv_time_stamp     (o_ts),
        .o_recv_std_time       (o_std),
        .o_recv_return_ts      (o_ret),
        .o_recv_ts_valid       (o_tsv),
        .o_recv_std_valid      (o_stdv),
        .o_recv_return_valid   (o_retv),
        .o_cur_slot_id         (o_slot),
        .o_dest_tor_mac        (o_mac),
        .o_syn_start           (o_syn),
        .o_err_cnt             (o_err)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    int          m_idx = 0;
    bit          m_drop = 0, m_bad = 0, m_pend = 0, m_over = 0;
    int          m_arm = 0;
    logic [15:0] m_b0 = '0;
    logic [47:0] m_pmac = '0;
    logic [3:0]  m_pid = '0;
    logic [63:0] exp_ts = '0, exp_std = '0, exp_ret = '0;
    logic        exp_tsv = 0, exp_stdv = 0, exp_retv = 0, exp_syn = 0;
    logic [3:0]  exp_slot = '0;
    logic [47:0] exp_mac = '0;
    logic [15:0] exp_err = '0;

    // Frame-level model: position in frame decides header, slot and limit handling.
    always @(posedge i_clk) begin
        exp_tsv = 0; exp_stdv = 0; exp_retv = 0; exp_syn = 0;
        if (i_rst) begin
            m_idx = 0; m_drop = 0; m_bad = 0; m_pend = 0; m_arm = 0;
            m_b0 = '0; m_pmac = '0; m_pid = '0;
            exp_ts = '0; exp_std = '0; exp_ret = '0;
            exp_slot = '0; exp_mac = '0; exp_err = '0;
        end else if (tvalid) begin
            m_over = !m_drop && !tlast && (m_idx + 1 >= MAXB);
            if (tuser) m_bad = 1;
            if (m_idx == 0) m_b0 = tdata[15:0];
            if (m_idx == 1 && tdata[31:16] == 16'hff03) begin
                m_pend = 1;
                m_pmac = {m_b0, tdata[63:32]};
                m_pid  = tdata[3:0];
            end
            if (m_arm != 0) begin
                if (!tuser && !m_over) begin
                    if (m_arm == 1) begin exp_ts  = tdata; exp_tsv  = 1; end
                    if (m_arm == 2) begin exp_std = tdata; exp_stdv = 1; end
                    if (m_arm == 3) begin exp_ret = tdata; exp_retv = 1; end
                end
                m_arm = 0;
            end else if (!m_drop && m_idx >= 1 && !tuser && !tlast && !m_over) begin
                if (tdata == 64'h66) m_arm = 1;
                else if (tdata == 64'h88) m_arm = 2;
                else if (tdata == 64'h55) m_arm = 3;
            end
            if (m_over) begin
                m_drop = 1;
                m_arm  = 0;
            end
            if (tlast) begin
                if (m_bad || m_drop) begin
                    if (exp_err != 16'hffff) exp_err = exp_err + 16'd1;
                end else if (m_pend) begin
                    exp_mac = m_pmac; exp_slot = m_pid; exp_syn = 1;
                end
                m_idx = 0; m_drop = 0; m_bad = 0; m_pend = 0; m_arm = 0;
            end else if (m_idx < 65535) begin
                m_idx = m_idx + 1;
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } pin_t;

    pin_t pins[$];
    int   pin_done = 0;
    bit   cmp_en = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_out(input int sel);
        case (sel)
            SEL_TS:   return o_ts;
            SEL_STD:  return o_std;
            SEL_RET:  return o_ret;
            SEL_TSV:  return 64'(o_tsv);
            SEL_STDV: return 64'(o_stdv);
            SEL_RETV: return 64'(o_retv);
            SEL_SLOT: return 64'(o_slot);
            SEL_MAC:  return 64'(o_mac);
            SEL_SYN:  return 64'(o_syn);
            default:  return 64'(o_err);
        endcase
    endfunction

    // Single compare process: model vs DUT every cycle, then any literal pins.
    always @(negedge i_clk) begin
        if (cmp_en) begin
            check("ts",       o_ts,           exp_ts);
            check("std",      o_std,          exp_std);
            check("ret",      o_ret,          exp_ret);
            check("ts_valid", 64'(o_tsv),     64'(exp_tsv));
            check("std_valid",64'(o_stdv),    64'(exp_stdv));
            check("ret_valid",64'(o_retv),    64'(exp_retv));
            check("slot_id",  64'(o_slot),    64'(exp_slot));
            check("dest_mac", 64'(o_mac),     64'(exp_mac));
            check("syn_start",64'(o_syn),     64'(exp_syn));
            check("err_cnt",  64'(o_err),     64'(exp_err));
        end
        while (pin_done < pins.size()) begin
            check(pins[pin_done].name, dut_out(pins[pin_done].sel), pins[pin_done].exp);
            pin_done++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic v, input logic [63:0] d, input logic l, input logic u);
        tvalid = v;
        tdata  = d;
        tlast  = l;
        tuser  = u;
        tkeep  = 8'($urandom);
        @(posedge i_clk);
        #1;
    endtask

    task automatic gap();
        send(1'b0, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    endtask

    task automatic pin(input string name, input int sel, input logic [63:0] exp);
        pin_t p;
        p.name = name;
        p.sel  = sel;
        p.exp  = exp;
        pins.push_back(p);
    endtask

    function automatic logic [63:0] rand_prefix();
        case ($urandom % 3)
            0:       return 64'h66;
            1:       return 64'h88;
            default: return 64'h55;
        endcase
    endfunction

    initial begin
        int          len;
        bit          slot;
        logic [63:0] d;

        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        cmp_en = 1;
        i_rst  = 1'b0;
        pin("rst_err", SEL_ERR, 64'h0);
        pin("rst_ts", SEL_TS, 64'h0);
        pin("rst_slot", SEL_SLOT, 64'h0);
        gap();

        // Slot-start frame commits MAC and ID one cycle after tlast.
        send(1, 64'h0000_0000_0000_AABB, 0, 0);
        send(1, 64'hCCDDEEFF_ff03_0005, 0, 0);
        send(1, 64'h1111, 0, 0);
        send(1, 64'h2222, 1, 0);
        pin("slot_syn", SEL_SYN, 64'h1);
        pin("slot_id", SEL_SLOT, 64'h5);
        pin("slot_mac", SEL_MAC, 64'h0000_AABB_CCDDEEFF);
        gap();
        pin("slot_syn_pulse", SEL_SYN, 64'h0);

        // Timestamp prefix followed by data on the last beat.
        send(1, 64'h1234, 0, 0);
        send(1, 64'h5678, 0, 0);
        send(1, 64'h66, 0, 0);
        pin("ts_not_yet", SEL_TSV, 64'h0);
        send(1, 64'h0123456789ABCDEF, 1, 0);
        pin("ts_val", SEL_TS, 64'h0123456789ABCDEF);
        pin("ts_strobe", SEL_TSV, 64'h1);
        gap();
        pin("ts_strobe_pulse", SEL_TSV, 64'h0);
        pin("ts_held", SEL_TS, 64'h0123456789ABCDEF);

        // Slot frame spoiled by tuser on its last beat.
        send(1, 64'hBEEF, 0, 0);
        send(1, 64'h01020304_ff03_0007, 0, 0);
        send(1, 64'h3333, 0, 0);
        send(1, 64'h4444, 1, 1);
        pin("bad_syn", SEL_SYN, 64'h0);
        pin("bad_slot", SEL_SLOT, 64'h5);
        pin("bad_mac", SEL_MAC, 64'h0000_AABB_CCDDEEFF);
        pin("bad_err", SEL_ERR, 64'h1);
        gap();

        // Oversized frame: std prefix on beat 15 lands on the drop beat.
        for (int i = 0; i < 20; i++) begin
            send(1, (i == 15) ? 64'h88 : 64'h1000 + 64'(i), i == 19, 0);
            if (i >= 15) pin("drop_no_std", SEL_STDV, 64'h0);
        end
        pin("drop_err", SEL_ERR, 64'h2);
        pin("drop_std", SEL_STD, 64'h0);
        gap();
        send(1, 64'h0102, 0, 0);
        send(1, 64'hA0B0C0D0_ff03_0009, 0, 0);
        send(1, 64'h88, 0, 0);
        send(1, 64'hCAFE, 1, 0);
        pin("after_drop_std", SEL_STD, 64'hCAFE);
        pin("after_drop_stdv", SEL_STDV, 64'h1);
        pin("after_drop_syn", SEL_SYN, 64'h1);
        pin("after_drop_slot", SEL_SLOT, 64'h9);
        pin("after_drop_mac", SEL_MAC, 64'h0000_0102_A0B0C0D0);
        pin("after_drop_err", SEL_ERR, 64'h2);
        gap();

        // Randomized frames with gaps, bad beats, prefixes and occasional reset.
        for (int f = 0; f < 400; f++) begin
            len  = int'($urandom_range(1, 22));
            slot = 1'($urandom);
            for (int i = 0; i < len; i++) begin
                while ($urandom % 4 == 0) gap();
                d = {$urandom, $urandom};
                if (i == 1 && slot) d[31:16] = 16'hff03;
                if (i >= 1 && $urandom % 4 == 0) d = rand_prefix();
                if ($urandom % 600 == 0) begin
                    i_rst = 1'b1;
                    send(1'($urandom), d, 1'($urandom), 1'($urandom));
                    i_rst = 1'b0;
                end else begin
                    send(1, d, i == len - 1, ($urandom % 20) == 0);
                end
            end
            if ($urandom % 2 == 0) gap();
        end

        // Reset mid-frame right after a prefix beat.
        send(1, 64'h1, 0, 0);
        send(1, 64'h2, 0, 0);
        send(1, 64'h66, 0, 0);
        i_rst = 1'b1;
        send(0, 64'h0, 0, 0);
        i_rst = 1'b0;
        for (int s = SEL_TS; s <= SEL_ERR; s++) pin("midrst_zero", s, 64'h0);
        send(1, 64'h0123456789ABCDEF, 1, 0);
        pin("midrst_no_tsv", SEL_TSV, 64'h0);
        pin("midrst_ts", SEL_TS, 64'h0);
        pin("midrst_err", SEL_ERR, 64'h0);

        // Error counter saturation.
        repeat (65534) send(1, 64'h0, 1, 1);
        pin("sat_fffe", SEL_ERR, 64'hfffe);
        for (int k = 0; k < 3; k++) begin
            send(1, 64'h0, 1, 1);
            pin("sat_ffff", SEL_ERR, 64'hffff);
        end

        gap();
        gap();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctrl_msg_rx.md
CTRL_MSG_RX -- requirements
Module: ctrl_msg_rx

Interface
REQ-001 SHALL have parameter P_SLOT_ID_TYPE, default 16'hff03: ethertype marking a slot-start frame.
REQ-002 SHALL have parameter P_SLOT_ID_W, default 4: slot ID width, 1..16.
REQ-003 SHALL have parameters P_TS_PRE, P_STD_PRE, P_RET_PRE, defaults 8'h66, 8'h88, 8'h55: message prefix codes.
REQ-004 SHALL have parameter P_MAX_BEATS, default 16: longest legal frame in beats, 3..65535.
REQ-005 SHALL have i_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have i_rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have s_ctrl_rx_axis_tvalid/tdata/tlast/tkeep/tuser, input, 1/64/1/8/1: AXIS receive stream with no tready; tuser=1 means bad beat.
REQ-008 SHALL have o_recv_time_stamp/o_recv_std_time/o_recv_return_ts, output, 64 each: held captured values.
REQ-009 SHALL have o_recv_ts_valid/o_recv_std_valid/o_recv_return_valid, output, 1 each: one-cycle capture strobes.
REQ-010 SHALL have o_cur_slot_id, output, P_SLOT_ID_W: last committed slot ID.
REQ-011 SHALL have o_dest_tor_mac, output, 48: last committed destination MAC.
REQ-012 SHALL have o_syn_start, output, 1: one-cycle slot-start strobe.
REQ-013 SHALL have o_err_cnt, output, 16: saturating count of bad frames.

Function
REQ-014 SHALL run FSM states IDLE, HDR, BODY, DROP; a beat is any cycle with tvalid=1.
REQ-015 SHALL move on each beat: IDLE->HDR; HDR->BODY; BODY->BODY; any state ->IDLE on tlast.
REQ-016 SHALL enter DROP on the beat that reaches P_MAX_BEATS without tlast, then stay in DROP until tlast, then go to IDLE.
REQ-017 SHALL treat a frame whose tlast arrives in IDLE (1-beat frame) or HDR (2-beat frame) as complete.
REQ-018 SHALL keep a 16-bit beat counter: 0 in IDLE, incremented per beat, cleared on tlast.
REQ-019 SHALL store beat0 tdata[15:0] and, if beat1 tdata[31:16]==P_SLOT_ID_TYPE, set a slot-pending flag holding MAC {beat0[15:0], beat1[63:32]} and ID beat1[P_SLOT_ID_W-1:0].
REQ-020 SHALL hold slot-pending results until tlast, then commit to o_dest_tor_mac and o_cur_slot_id and pulse o_syn_start the cycle after tlast, only if no beat of the frame had tuser=1 and the frame never entered DROP.
REQ-021 SHALL treat a beat as a prefix beat when tdata=={56'h0, prefix} in HDR or BODY with tuser=0 and tlast=0; this arms a capture for that message type.
REQ-022 SHALL, on the next beat after arming with tuser=0, latch tdata into the matching 64-bit output and pulse the matching strobe the following cycle (one-cycle latency); that capture beat may be tlast.
REQ-023 SHALL disarm the capture on the capture beat, on any tuser=1 beat, on tlast, and on entry to DROP.
REQ-024 SHALL allow only one armed type at a time; a prefix beat while armed is captured as data, not as a new prefix.
REQ-025 SHALL hold captured values until the next capture of the same type.
REQ-026 SHALL increment o_err_cnt by 1 the cycle after tlast of a frame that had a tuser=1 beat or entered DROP, and hold it at 16'hffff once reached.
REQ-027 SHALL ignore tkeep.
REQ-028 SHALL not change any state in cycles with tvalid=0; a gap inside a frame keeps FSM state and the armed flag.

Reset
REQ-029 SHALL, while i_rst=1 at a clock edge, return the FSM to IDLE and clear the counters, flags, armed state, all strobes, all 64-bit outputs, o_cur_slot_id, o_dest_tor_mac and o_err_cnt to 0.
REQ-030 SHALL discard a frame interrupted by reset; its remaining beats are parsed as a new frame.

Verification
REQ-031 SHALL check: 4-beat frame {0x..AABB, 0xCCDDEEFF_ff03_0005, X, Y tlast}, tuser=0 -> one cycle after tlast, o_syn_start=1, o_cur_slot_id=5, o_dest_tor_mac=48'hAABB_CCDDEEFF.
REQ-032 SHALL check: beats {H0, H1, 0x66, 0x0123456789ABCDEF tlast} -> o_recv_time_stamp=0x0123456789ABCDEF, o_recv_ts_valid high for exactly one cycle, one cycle after the last beat.
REQ-033 SHALL check: the REQ-031 frame with tuser=1 on its tlast -> no o_syn_start, slot outputs unchanged, o_err_cnt 0->1.
REQ-034 SHALL check: a 20-beat frame with P_MAX_BEATS=16 and 0x88 on beat 15 -> DROP entered, no std capture, o_err_cnt+1, next frame parsed normally.
REQ-035 SHALL check: i_rst asserted mid-frame after a prefix beat -> no strobe, all outputs 0; o_err_cnt preloaded at 16'hfffe saturates at 16'hffff after 3 bad frames.
